// File: rtl/tile_pkg.sv
// Shared tile-memory types used by the renderers and the tile ROM arbiter.
package tile_pkg;

    localparam int TILE_ADDR_W  = 13;
    localparam int TILE_COLOR_W = 24;

    typedef logic [TILE_ADDR_W-1:0]  tile_addr_t;
    typedef logic [TILE_COLOR_W-1:0] tile_rgb_t;

    // Round-robin successor of index g among n slots.
    function automatic int rr_next(input int g, input int n);
        return (g + 1) % n;
    endfunction

endpackage

// File: rtl/tile_mem_arbiter_if.sv
// Request/response/ROM bus between the renderers, the tile ROM and the arbiter.
interface tile_mem_arbiter_if
    import tile_pkg::*;
#(
    parameter int NUM_REQ    = 3,
    parameter int ADDRESS    = TILE_ADDR_W,
    parameter int COLOR_BITS = TILE_COLOR_W
);
    localparam int IW = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ*ADDRESS-1:0]    req_addr;
    logic [NUM_REQ-1:0]            req_ready;
    logic [NUM_REQ-1:0]            rsp_valid;
    logic [NUM_REQ*COLOR_BITS-1:0] rsp_data;
    logic [NUM_REQ-1:0]            rsp_ready;
    logic [ADDRESS-1:0]            mem_addr;
    logic [COLOR_BITS-1:0]         mem_dout;
    logic [IW-1:0]                 grant_id;

    modport master (
        output req_valid, req_addr, rsp_ready, mem_dout,
        input  req_ready, rsp_valid, rsp_data, mem_addr, grant_id
    );

    modport slave (
        input  req_valid, req_addr, rsp_ready, mem_dout,
        output req_ready, rsp_valid, rsp_data, mem_addr, grant_id
    );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first eligible index at or after ptr, with wrap.
module rr_arbiter
    import tile_pkg::*;
#(
    parameter int N = 3
) (
    input  logic [N-1:0]         eligible,
    input  logic [$clog2(N)-1:0] ptr,
    output logic [N-1:0]         grant,
    output logic [$clog2(N)-1:0] grant_idx
);
    localparam int IW = $clog2(N);

    logic found;
    int   idx;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = 0;
        for (int k = 0; k < N; k++) begin
            idx = (int'(ptr) + k) % N;
            if (!found && eligible[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = IW'(idx);
            end
        end
    end

endmodule

// File: rtl/tile_mem_arbiter.sv
// Round-robin arbiter sharing the async-read tile color ROM among NUM_REQ requesters.
// Optional macro TILE_ARB_PRIO0_EN gives requester 0 (scanout) absolute priority.
module tile_mem_arbiter
    import tile_pkg::*;
#(
    parameter int NUM_REQ    = 3,
    parameter int ADDRESS    = TILE_ADDR_W,
    parameter int COLOR_BITS = TILE_COLOR_W
) (
    input logic               clk,
    input logic               rst_n,
    tile_mem_arbiter_if.slave bus
);
    localparam int IW = $clog2(NUM_REQ);

`ifdef TILE_ARB_PRIO0_EN
    localparam logic [IW-1:0] RR_RESET = IW'(1);
`else
    localparam logic [IW-1:0] RR_RESET = '0;
`endif

    logic [IW-1:0]                 rr_ptr, rr_ptr_next;
    logic [ADDRESS-1:0]            mem_addr_q, mem_addr;
    logic [NUM_REQ-1:0]            rsp_valid_q;
    logic [NUM_REQ*COLOR_BITS-1:0] rsp_data_q;
    logic [NUM_REQ-1:0]            eligible, rr_elig, rr_grant, grant;
    logic [IW-1:0]                 rr_idx, grant_idx;
    logic                          granted;

    // A full response slot blocks its requester unless it drains this cycle.
    assign eligible = bus.req_valid & (~rsp_valid_q | bus.rsp_ready) & {NUM_REQ{rst_n}};

`ifdef TILE_ARB_PRIO0_EN
    assign rr_elig = eligible & {{(NUM_REQ-1){1'b1}}, 1'b0};
`else
    assign rr_elig = eligible;
`endif

    rr_arbiter #(.N(NUM_REQ)) u_rr (
        .eligible  (rr_elig),
        .ptr       (rr_ptr),
        .grant     (rr_grant),
        .grant_idx (rr_idx)
    );

    always_comb begin
        grant     = rr_grant;
        grant_idx = rr_idx;
`ifdef TILE_ARB_PRIO0_EN
        if (eligible[0]) begin
            grant     = NUM_REQ'(1);
            grant_idx = '0;
        end
`endif
    end

    assign granted = |grant;

    // Without a grant the ROM keeps seeing the last address so its output stays quiet.
    always_comb begin
        mem_addr = mem_addr_q;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) mem_addr = bus.req_addr[i*ADDRESS +: ADDRESS];
        end
    end

    always_comb begin
        rr_ptr_next = rr_ptr;
        if (granted) rr_ptr_next = IW'(rr_next(int'(grant_idx), NUM_REQ));
`ifdef TILE_ARB_PRIO0_EN
        if (granted && grant_idx == '0) rr_ptr_next = rr_ptr;
        if (rr_ptr_next == '0) rr_ptr_next = IW'(1);
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr     <= RR_RESET;
            mem_addr_q <= '0;
        end else begin
            rr_ptr <= rr_ptr_next;
            if (granted) mem_addr_q <= mem_addr;
        end
    end

    // A grant in the same cycle as a drain refills the slot, so it wins over the clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (grant[i]) begin
                    rsp_valid_q[i]                         <= 1'b1;
                    rsp_data_q[i*COLOR_BITS +: COLOR_BITS] <= bus.mem_dout;
                end else if (bus.rsp_ready[i]) begin
                    rsp_valid_q[i] <= 1'b0;
                end
            end
        end
    end

    assign bus.req_ready = grant;
    assign bus.grant_id  = grant_idx;
    assign bus.mem_addr  = mem_addr;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;

endmodule

// File: doc/tile_mem_arbiter.md
# tile_mem_arbiter

Round-robin arbiter sharing the single-port, asynchronous-read tile color ROM between NUM_REQ requesters (background renderer, sprite renderer, and similar). Each requester issues tile addresses over a valid/ready handshake. The arbiter drives the ROM address, samples the 24-bit RGB word, and returns it on a per-requester response channel with backpressure. It sits between the renderers and the tile memory, and is the only driver of the ROM address bus.

## Interface
- NUM_REQ, 3, number of requesters (2..8)
- ADDRESS, 13, tile ROM address width
- COLOR_BITS, 24, tile ROM data width
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  NUM_REQ  per-requester read request
- req_addr  in  NUM_REQ*ADDRESS  packed addresses; requester i at [i*ADDRESS +: ADDRESS]
- req_ready  out  NUM_REQ  one-hot grant; handshake = req_valid[i] & req_ready[i]
- rsp_valid  out  NUM_REQ  response held for requester i
- rsp_data  out  NUM_REQ*COLOR_BITS  packed response words, registered
- rsp_ready  in  NUM_REQ  requester i consumes its response
- mem_addr  out  ADDRESS  tile ROM address
- mem_dout  in  COLOR_BITS  tile ROM async read data
- grant_id  out  $clog2(NUM_REQ)  index of the current grant (debug/perf)

## Operation
- A requester is eligible when `req_valid[i] & (~rsp_valid[i] | rsp_ready[i])`, i.e. its response slot is empty or drains this cycle.
- At most one grant per cycle; req_ready is one-hot or zero and is combinational from the eligibility vector and the pointer.
- Round robin: search starts at rr_ptr, ascending with wrap. After a grant to g, rr_ptr <= (g+1) mod NUM_REQ. With no grant, rr_ptr holds.
- mem_addr = req_addr of the granted requester. With no grant, mem_addr holds its last registered value (mem_addr_q), so the ROM output stays stable.
- On handshake with g: rsp_data[g] <= mem_dout and rsp_valid[g] <= 1 at the next edge.
- rsp_valid[i] clears on `rsp_valid[i] & rsp_ready[i]` unless the same cycle grants i. Simultaneous drain and new grant: data is replaced and valid stays 1.
- rsp_data[i] holds while rsp_valid[i] & ~rsp_ready[i]; there is no overwrite under backpressure.
- grant_id = index of the granted requester; 0 when there is no grant.

## Timing
- Request-to-response latency is 1 cycle: handshake at edge n, rsp_valid/rsp_data valid after edge n+1.
- Aggregate throughput is 1 read/cycle. A single requester with rsp_ready tied high sustains 1 read/cycle.
- Reset values (asynchronous, rst_n=0):
  - rsp_valid = 0
  - rsp_data = 0
  - rr_ptr = 0
  - mem_addr_q = 0
- While rst_n=0, req_ready = 0 and mem_addr = 0.
- Reset asserted mid-transaction discards pending responses. The first grant after deassertion goes to the lowest-index eligible requester.
- All inputs are sampled on the rising edge of clk. The mem_dout path, mem_addr → ROM → rsp_data, is a single-cycle combinational path.

## Configuration
- TILE_ARB_PRIO0_EN defined:
  - Requester 0 (display scanout) wins whenever eligible.
  - Round robin applies only among requesters 1..NUM_REQ-1.
  - rr_ptr never points to 0 and does not advance on grants to requester 0.
- Not defined: plain round robin across all NUM_REQ requesters, as described above.

## Structure
- Package tile_pkg:
  - localparams TILE_ADDR_W=13 and TILE_COLOR_W=24
  - typedefs tile_addr_t and tile_rgb_t
  - The renderers and this block share this package.
- Sub-module rr_arbiter:
  - parameter N
  - inputs: eligible vector, pointer
  - outputs: one-hot grant, encoded index
  - combinational; instantiated once. The priority override under TILE_ARB_PRIO0_EN is applied in the wrapper, not in rr_arbiter.
- The top-level holds rr_ptr, mem_addr_q, and the per-requester response registers.

## Test plan
- Reset with all req_valid=1 → req_ready=0, rsp_valid=0, mem_addr=0. After deassertion, the first grant is req 0.
- NUM_REQ=3, all requesters valid continuously, all rsp_ready=1 → grant order 0,1,2,0,1,2. Each rsp_data equals ROM[addr] one cycle after its grant.
- Req 1 has rsp_valid=1 with rsp_ready=0 and req_valid=1 → req 1 is never granted and rsp_data[1] stays unchanged. Raising rsp_ready: granted the same cycle, new data the next cycle.
- Single requester 2, addr 0x0000..0x1FFF back-to-back with rsp_ready=1 → 1 response/cycle, and the last word equals ROM[0x1FFF].
- rst_n pulsed low while rsp_valid[0]=1 → rsp_valid[0] clears asynchronously and no stale response appears after reset.
- With TILE_ARB_PRIO0_EN, req 0 toggling every other cycle and reqs 1,2 constant → req 0 is granted on every cycle it is valid. Reqs 1,2 alternate 1,2,1,2 in the remaining cycles.
